// File: rtl/conv_stream_engine.sv
// Streaming KxK convolution engine: raster pixels in, valid-padding stride-1 results out.
// Optional CONV_RELU_EN clamps negative results to zero before they are registered.
module conv_stream_engine #(
   parameter int DATA_WIDTH   = 20,
   parameter int WEIGHT_WIDTH = 8,
   parameter int IFM_WIDTH    = 8,
   parameter int KERNEL_SIZE  = 3,
   parameter int IMG_WIDTH    = 8,
   parameter int IMG_HEIGHT   = 8
) (
   input  logic                                        clk1,
   input  logic                                        rst_n,
   input  logic                                        set_wgt,
   input  logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] wgt,
   input  logic                                        ifm_valid,
   output logic                                        ifm_ready,
   input  logic [IFM_WIDTH-1:0]                        ifm,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [DATA_WIDTH-1:0]                       data_output,
   output logic                                        out_last
);

   localparam int K      = KERNEL_SIZE;
   localparam int KK     = K * K;
   localparam int WGT_W  = WEIGHT_WIDTH * KK;
   localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   // K-1 full rows of history plus the K-1 older pixels of the current window row
   localparam int LB_LEN = (K - 1) * IMG_WIDTH + K - 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_WIN  = COL_W'(K - 1);
   localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(K - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t                   state_reg;
   logic                     wgt_loaded_reg;
   logic [WGT_W-1:0]         wgt_reg;
   logic [COL_W-1:0]         col_reg;
   logic [ROW_W-1:0]         row_reg;
   logic [IFM_WIDTH-1:0]     lb_reg [LB_LEN];
   logic                     out_valid_reg;
   logic                     out_last_reg;
   logic [DATA_WIDTH-1:0]    data_reg;

   logic                     accept;
   logic                     consume;
   logic                     pix_last;
   logic                     win_done;
   logic [DATA_WIDTH-1:0]    prod [KK];
   logic [DATA_WIDTH-1:0]    sum_next;
   logic [DATA_WIDTH-1:0]    result_next;

   always_comb begin
      ifm_ready = 1'b0;
      case (state_reg)
         S_IDLE:  ifm_ready = wgt_loaded_reg;
         S_RUN:   ifm_ready = !out_valid_reg || out_ready;
         default: ifm_ready = 1'b0;
      endcase
   end

   assign accept      = ifm_valid && ifm_ready;
   assign consume     = out_valid_reg && out_ready;
   assign pix_last    = (row_reg == ROW_LAST) && (col_reg == COL_LAST);
   assign win_done    = (row_reg >= ROW_WIN) && (col_reg >= COL_WIN);
   assign out_valid   = out_valid_reg;
   assign out_last    = out_last_reg;
   assign data_output = data_reg;

   // Pixel history: index 0 is the pixel accepted one handshake ago.
   generate
      for (genvar gi = 0; gi < LB_LEN; gi++) begin : g_lb
         always_ff @(posedge clk1) begin
            if (rst_n) begin
               lb_reg[gi] <= '0;
            end else if (accept) begin
               if (gi == 0) lb_reg[gi] <= ifm;
               else         lb_reg[gi] <= lb_reg[(gi > 0) ? gi - 1 : 0];
            end
         end
      end
   endgenerate

   // Window taps include the pixel being accepted, so the result is ready on its edge.
   // Arithmetic is done modulo 2^DATA_WIDTH, which equals truncating the guarded full sum.
   generate
      for (genvar gi = 0; gi < KK; gi++) begin : g_tap
         localparam int RI = gi / K;
         localparam int CJ = gi % K;
         localparam int D  = (K - 1 - RI) * IMG_WIDTH + (K - 1 - CJ);
         logic [IFM_WIDTH-1:0]  pix;
         logic [DATA_WIDTH-1:0] pix_ext;
         logic [DATA_WIDTH-1:0] wgt_ext;
         if (D == 0) begin : g_new
            assign pix = ifm;
         end else begin : g_old
            assign pix = lb_reg[D - 1];
         end
         assign pix_ext  = DATA_WIDTH'(pix);
         assign wgt_ext  = DATA_WIDTH'($signed(wgt_reg[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
         assign prod[gi] = pix_ext * wgt_ext;
      end
   endgenerate

   always_comb begin
      sum_next = '0;
      for (int n = 0; n < KK; n++) begin
         sum_next = sum_next + prod[n];
      end
   end

`ifdef CONV_RELU_EN
   assign result_next = sum_next[DATA_WIDTH-1] ? '0 : sum_next;
`else
   assign result_next = sum_next;
`endif

   always_ff @(posedge clk1) begin
      if (rst_n) begin
         state_reg      <= S_IDLE;
         wgt_loaded_reg <= 1'b0;
         wgt_reg        <= '0;
         col_reg        <= '0;
         row_reg        <= '0;
         out_valid_reg  <= 1'b0;
         out_last_reg   <= 1'b0;
         data_reg       <= '0;
      end else begin
         if (accept && win_done) begin
            data_reg      <= result_next;
            out_valid_reg <= 1'b1;
            out_last_reg  <= pix_last;
         end else if (consume) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
         end

         if (accept) begin
            if (pix_last) begin
               col_reg <= '0;
               row_reg <= '0;
            end else if (col_reg == COL_LAST) begin
               col_reg <= '0;
               row_reg <= row_reg + 1'b1;
            end else begin
               col_reg <= col_reg + 1'b1;
            end
         end

         case (state_reg)
            S_IDLE: begin
               if (set_wgt) begin
                  wgt_reg        <= wgt;
                  wgt_loaded_reg <= 1'b1;
               end
               if (accept) state_reg <= pix_last ? S_FLUSH : S_RUN;
            end
            S_RUN: begin
               if (accept && pix_last) state_reg <= S_FLUSH;
            end
            S_FLUSH: begin
               if (consume) state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed bench for conv_stream_engine on an 8x8 frame with a 3x3 kernel.
// Expected results follow CONV_RELU_EN when the macro is defined for the build.
module tb_conv_stream_engine;

   localparam int DW = 20;
   localparam int WW = 8;
   localparam int IW = 8;
   localparam int K  = 3;
   localparam int W  = 8;
   localparam int H  = 8;
   localparam int NPIX = W * H;
   localparam int NOUT = (H - K + 1) * (W - K + 1);

   localparam logic [WW*K*K-1:0] WGT_ONES   = {9{8'h01}};
   localparam logic [WW*K*K-1:0] WGT_NEG    = {9{8'hFF}};
   localparam logic [WW*K*K-1:0] WGT_CENTRE = 72'h01 << 32;

   logic              clk1 = 1'b0;
   logic              rst_n;
   logic              set_wgt;
   logic [WW*K*K-1:0] wgt;
   logic              ifm_valid;
   logic              ifm_ready;
   logic [IW-1:0]     ifm;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     data_output;
   logic              out_last;

   int n_checks = 0;
   int n_errors = 0;

   conv_stream_engine #(
      .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .IFM_WIDTH(IW),
      .KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)
   ) dut (
      .clk1(clk1), .rst_n(rst_n), .set_wgt(set_wgt), .wgt(wgt),
      .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm(ifm),
      .out_valid(out_valid), .out_ready(out_ready),
      .data_output(data_output), .out_last(out_last)
   );

   always #5 clk1 = ~clk1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // mode 0: all-ones weights, constant 2; mode 1: centre weight, ramp; mode 2: all -1, constant 2
   function automatic logic [IW-1:0] pix_val(input int mode, input int idx);
      logic [31:0] v;
      v = (mode == 1) ? idx : 2;
      return v[IW-1:0];
   endfunction

   function automatic logic [31:0] exp_val(input int mode, input int k);
      case (mode)
         0: return 32'd18;
         1: return ((k / (W - K + 1)) + 1) * W + (k % (W - K + 1)) + 1;
`ifdef CONV_RELU_EN
         default: return 32'd0;
`else
         default: return 32'h000FFFEE;
`endif
      endcase
   endfunction

   task automatic load_weights(input logic [WW*K*K-1:0] w);
      @(negedge clk1);
      wgt     = w;
      set_wgt = 1'b1;
      @(negedge clk1);
      set_wgt = 1'b0;
   endtask

   task automatic run_frame(input int mode, input bit stall, input bit midload);
      int pix = 0;
      int recv = 0;
      int stall_done = 0;
      int cyc = 0;
      while (recv < NOUT && cyc < 3000) begin
         @(negedge clk1);
         cyc++;
         set_wgt = 1'b0;
         if (midload && pix == 30) begin
            wgt     = WGT_ONES;
            set_wgt = 1'b1;
         end
         ifm_valid = (pix < NPIX);
         ifm       = pix_val(mode, pix);
         out_ready = 1'b1;
         if (stall && recv == 9 && out_valid && stall_done < 5) begin
            out_ready = 1'b0;
            stall_done++;
         end
         #1;
         if (!out_ready) begin
            check("stall_ifm_ready", ifm_ready, 0);
            check("stall_hold", data_output, exp_val(mode, 9));
         end
         if (pix >= NPIX && out_valid) check("flush_ifm_ready", ifm_ready, 0);
         if (out_valid && out_ready) begin
            check($sformatf("data[%0d]", recv), data_output, exp_val(mode, recv));
            check($sformatf("last[%0d]", recv), out_last, (recv == NOUT - 1));
            recv++;
         end
         if (ifm_valid && ifm_ready) pix++;
      end
      if (recv < NOUT) check("frame_timeout", recv, NOUT);
      if (stall) check("stall_cycles", stall_done, 5);
      @(negedge clk1);
      ifm_valid = 1'b0;
      set_wgt   = 1'b0;
      #1;
      check("idle_ifm_ready", ifm_ready, 1);
      check("idle_out_valid", out_valid, 0);
      $display("frame mode=%0d stall=%0d midload=%0d: %0d outputs in %0d cycles",
               mode, stall, midload, recv, cyc);
   endtask

   initial begin
      int acc;
      int cyc;
      rst_n     = 1'b1;
      set_wgt   = 1'b0;
      wgt       = '0;
      ifm_valid = 1'b0;
      ifm       = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk1);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_data", data_output, 0);
      check("rst_out_last", out_last, 0);
      check("rst_ifm_ready", ifm_ready, 0);
      @(negedge clk1);
      rst_n = 1'b0;
      #1;
      check("no_wgt_ifm_ready", ifm_ready, 0);

      load_weights(WGT_ONES);
      #1;
      check("loaded_ifm_ready", ifm_ready, 1);
      run_frame(0, 1'b0, 1'b0);

      load_weights(WGT_CENTRE);
      run_frame(1, 1'b0, 1'b0);
      run_frame(1, 1'b1, 1'b0);

      load_weights(WGT_NEG);
      run_frame(2, 1'b0, 1'b0);

      // Abort a frame after 20 accepted pixels
      load_weights(WGT_CENTRE);
      acc = 0;
      cyc = 0;
      while (acc < 20 && cyc < 200) begin
         @(negedge clk1);
         cyc++;
         ifm_valid = 1'b1;
         ifm       = pix_val(1, acc);
         out_ready = 1'b1;
         #1;
         if (ifm_ready) acc++;
      end
      check("abort_accepted", acc, 20);
      @(negedge clk1);
      ifm_valid = 1'b0;
      rst_n     = 1'b1;
      @(negedge clk1);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_ifm_ready", ifm_ready, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk1);
         ifm_valid = 1'b1;
         #1;
         check("abort_ignored_ready", ifm_ready, 0);
         check("abort_ignored_valid", out_valid, 0);
      end
      @(negedge clk1);
      ifm_valid = 1'b0;
      $display("abort after %0d pixels checked", acc);

      load_weights(WGT_CENTRE);
      run_frame(1, 1'b0, 1'b0);
      run_frame(1, 1'b0, 1'b1);
      load_weights(WGT_ONES);
      run_frame(0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
